// File: rtl/palette_arb.sv
// Palette RAM sequencer: fill > copper > host write arbitration and video/host read sharing.
// Define PALETTE_READBACK_EN to enable host readback through the shared read port.
module palette_arb (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        vid_blank_i,
    input  logic        vid_rd_en_i,
    input  logic [7:0]  vid_rd_addr_i,
    input  logic        cop_req_i,
    input  logic [7:0]  cop_addr_i,
    input  logic [15:0] cop_data_i,
    output logic        cop_ack_o,
    input  logic        host_req_i,
    input  logic [7:0]  host_addr_i,
    input  logic [15:0] host_data_i,
    output logic        host_ack_o,
    input  logic        host_rd_req_i,
    input  logic [7:0]  host_rd_addr_i,
    output logic        host_rd_ack_o,
    output logic [15:0] host_rd_data_o,
    input  logic        fill_req_i,
    input  logic [15:0] fill_data_i,
    output logic        fill_busy_o,
    output logic        pal_wr_en_o,
    output logic [7:0]  pal_wr_addr_o,
    output logic [15:0] pal_wr_data_o,
    output logic        pal_rd_en_o,
    output logic [7:0]  pal_rd_addr_o,
    input  logic [15:0] pal_rd_data_i
);

    typedef enum logic {IDLE, FILL} fill_st_t;

    fill_st_t    fill_st;
    logic [7:0]  fill_cnt;
    logic [15:0] fill_data;
    logic        fill_go;
    logic        cop_go;
    logic        host_go;

    // One-hot grant; a requester whose ack is high this cycle is masked.
    always_comb begin
        fill_go = 1'b0;
        cop_go  = 1'b0;
        host_go = 1'b0;
        if (fill_st == IDLE) begin
            fill_go = fill_req_i;
            cop_go  = !fill_req_i && cop_req_i && !cop_ack_o;
            host_go = !fill_req_i && !cop_go && host_req_i && !host_ack_o;
        end
    end

    assign fill_busy_o = (fill_st == FILL);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            fill_st       <= IDLE;
            fill_cnt      <= '0;
            fill_data     <= '0;
            pal_wr_en_o   <= 1'b0;
            pal_wr_addr_o <= '0;
            pal_wr_data_o <= '0;
            cop_ack_o     <= 1'b0;
            host_ack_o    <= 1'b0;
        end else begin
            pal_wr_en_o <= 1'b0;
            cop_ack_o   <= 1'b0;
            host_ack_o  <= 1'b0;
            if (fill_st == FILL) begin
                if (fill_cnt == 8'hFF) begin
                    fill_st  <= IDLE;
                    fill_cnt <= '0;
                end else begin
                    fill_cnt      <= fill_cnt + 8'd1;
                    pal_wr_en_o   <= 1'b1;
                    pal_wr_addr_o <= fill_cnt + 8'd1;
                    pal_wr_data_o <= fill_data;
                end
            end else begin
                unique case (1'b1)
                    fill_go: begin
                        fill_st       <= FILL;
                        fill_cnt      <= '0;
                        fill_data     <= fill_data_i;
                        pal_wr_en_o   <= 1'b1;
                        pal_wr_addr_o <= '0;
                        pal_wr_data_o <= fill_data_i;
                    end
                    cop_go: begin
                        pal_wr_en_o   <= 1'b1;
                        pal_wr_addr_o <= cop_addr_i;
                        pal_wr_data_o <= cop_data_i;
                        cop_ack_o     <= 1'b1;
                    end
                    host_go: begin
                        pal_wr_en_o   <= 1'b1;
                        pal_wr_addr_o <= host_addr_i;
                        pal_wr_data_o <= host_data_i;
                        host_ack_o    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PALETTE_READBACK_EN
    typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_WAIT} rd_st_t;

    rd_st_t      rd_st;
    logic [7:0]  rd_addr;
    logic [15:0] rd_hold;
    logic        rd_issue;

    // Host only owns the read port while blanking persists through the issue cycle.
    assign rd_issue       = (rd_st == RD_ISSUE) && vid_blank_i;
    assign pal_rd_en_o    = rd_issue || vid_rd_en_i;
    assign pal_rd_addr_o  = rd_issue ? rd_addr : vid_rd_addr_i;
    assign host_rd_ack_o  = (rd_st == RD_WAIT);
    assign host_rd_data_o = host_rd_ack_o ? pal_rd_data_i : rd_hold;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            rd_st   <= RD_IDLE;
            rd_addr <= '0;
            rd_hold <= '0;
        end else begin
            unique case (rd_st)
                RD_IDLE: begin
                    if (host_rd_req_i && vid_blank_i && !host_rd_ack_o) begin
                        rd_addr <= host_rd_addr_i;
                        rd_st   <= RD_ISSUE;
                    end
                end
                RD_ISSUE: rd_st <= vid_blank_i ? RD_WAIT : RD_IDLE;
                RD_WAIT: begin
                    rd_hold <= pal_rd_data_i;
                    rd_st   <= RD_IDLE;
                end
                default: rd_st <= RD_IDLE;
            endcase
        end
    end
`else
    logic rd_s1;
    logic unused_rd;

    assign pal_rd_en_o    = vid_rd_en_i;
    assign pal_rd_addr_o  = vid_rd_addr_i;
    assign host_rd_data_o = '0;
    assign unused_rd      = ^{pal_rd_data_i, host_rd_addr_i, vid_blank_i};

    // Dummy two-cycle acknowledge so a host read never stalls.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            rd_s1         <= 1'b0;
            host_rd_ack_o <= 1'b0;
        end else begin
            rd_s1         <= host_rd_req_i && !rd_s1 && !host_rd_ack_o;
            host_rd_ack_o <= rd_s1;
        end
    end
`endif

endmodule

// File: doc/palette_arb.md
# palette_arb

Sequencer and arbiter for the 256×16 dual-port palette RAM. It shares the palette write port between the copper and the host register interface, and runs a hardware fill engine that writes one value to all 256 entries. It also shares the palette read port between the video pipeline and host readback, which happens during blanking only. It sits between the register/copper blocks and the palette RAM instance, and the write and read ports of that RAM are clocked from the same `clk`.

## Interface
Parameters:
- none (palette depth fixed at 256, data width 16)

Ports:
- `clk` in 1: single clock for all logic; palette RAM `wr_clk` is tied to this same clock.
- `reset_i` in 1: synchronous, active-high reset.
- `vid_blank_i` in 1: 1 = video is in blanking and the read port is free for host use.
- `vid_rd_en_i` in 1, `vid_rd_addr_i` in 8: video palette lookup request.
- `cop_req_i` in 1, `cop_addr_i` in 8, `cop_data_i` in 16: copper write request.
- `cop_ack_o` out 1: copper write accepted (one-cycle pulse).
- `host_req_i` in 1, `host_addr_i` in 8, `host_data_i` in 16: host write request.
- `host_ack_o` out 1: host write accepted (one-cycle pulse).
- `host_rd_req_i` in 1, `host_rd_addr_i` in 8: host read request.
- `host_rd_ack_o` out 1: host read complete (one-cycle pulse).
- `host_rd_data_o` out 16: host read data, valid while `host_rd_ack_o`=1 and held until the next ack.
- `fill_req_i` in 1, `fill_data_i` in 16: start fill (sampled on a single cycle).
- `fill_busy_o` out 1: fill in progress.
- `pal_wr_en_o` out 1, `pal_wr_addr_o` out 8, `pal_wr_data_o` out 16: to the palette RAM write port.
- `pal_rd_en_o` out 1, `pal_rd_addr_o` out 8: to the palette RAM read port.
- `pal_rd_data_i` in 16: palette RAM read data, registered in the RAM with 1-cycle latency.

## Operation
**Write arbitration** (evaluated each cycle; `pal_wr_*`, `cop_ack_o` and `host_ack_o` are registered):
- Priority: fill > copper > host.
- A requester is granted when its req=1 and its ack is not high this cycle. This ack mask prevents a held req from being written twice, so each requester gets at most one write per 2 cycles.
- On grant: next cycle `pal_wr_en_o`=1 with the granted addr/data, and the matching ack=1.
- Requesters hold req/addr/data stable until they see ack.

**Fill engine** (states IDLE and FILL):
- IDLE→FILL when `fill_req_i`=1. `fill_data_i` is latched and the counter is set to 0.
- In FILL:
  - `pal_wr_en_o`=1 every cycle; `pal_wr_addr_o` = counter; counter +1.
  - After the write to address 255, the state returns to IDLE.
  - The 8-bit counter wraps 255→0 only at that exit.
- `fill_busy_o`=1 in every FILL cycle (256 cycles).
- `fill_req_i` during FILL is ignored.
- Copper and host are not acked during FILL; their requests stay pending.

**Read port sharing** (host read FSM states RD_IDLE, RD_ISSUE, RD_WAIT):
- `vid_blank_i`=0: `pal_rd_en_o`/`pal_rd_addr_o` pass `vid_rd_*` through combinationally, with no added latency.
- RD_IDLE→RD_ISSUE when `host_rd_req_i`=1, `vid_blank_i`=1 and `host_rd_ack_o`=0. The address is latched.
- RD_ISSUE:
  - If `vid_blank_i`=1: drive `pal_rd_en_o`=1 with the latched address, then go to RD_WAIT.
  - If `vid_blank_i`=0: video owns the port, the host read is aborted back to RD_IDLE, and it retries while req is held.
- RD_WAIT: capture `pal_rd_data_i` into `host_rd_data_o`, pulse `host_rd_ack_o`, then go to RD_IDLE.
- In blank cycles with no host issue, the video passthrough still applies.

**Reset:** all outputs 0, the FSMs go to IDLE/RD_IDLE, and latched data is cleared. Asserting reset mid-fill or mid-read abandons the operation, and no ack is issued.

## Timing
- Write: req sampled at edge N; `pal_wr_en_o` and ack high in cycle N+1; RAM updated at edge N+1.
- Fill: `fill_req_i` at edge N; writes to addresses 0..255 occupy cycles N+1..N+256; `fill_busy_o` falls in cycle N+257.
- Host read: req sampled at N (blank=1); issue in cycle N+1; `host_rd_ack_o` and data valid in cycle N+2. Minimum spacing between reads is 3 cycles.
- Simultaneous copper and host requests: the copper is acked at N+1. The host is acked at N+2 only if the copper has dropped its req or is masked by its ack; otherwise the host waits for the next free slot.

## Configuration
- `PALETTE_READBACK_EN` defined: host read FSM and read-port sharing as described above.
- Not defined:
  - Read port is pure video passthrough at all times.
  - `host_rd_req_i` still gets a `host_rd_ack_o` pulse 2 cycles after it is sampled, with `host_rd_data_o`=0, so the host never hangs.

## Test plan
- **Reset:** assert `reset_i` for 2 cycles → every output 0, `fill_busy_o`=0.
- **Contention:** copper (addr 0x10, data 0x0F00) and host (addr 0x20, data 0x00F0) both request at N → `pal_wr` 0x10/0x0F00 with `cop_ack_o` in cycle N+1; 0x20/0x00F0 with `host_ack_o` after that; no duplicate writes.
- **Fill:** `fill_req_i` with data 0x0555; host write request during the fill → 256 consecutive writes to 0..255 of 0x0555, `fill_busy_o` high for 256 cycles, host acked only after the fill and its value persists at its address.
- **Readback:** write 0x0ABC to 0x07; `host_rd_req_i` for 0x07 with `vid_blank_i`=1 → `host_rd_ack_o` 2 cycles later with data 0x0ABC.
- **Blank drop:** `vid_blank_i` falls in the RD_ISSUE cycle → the read port follows `vid_rd_addr_i`, no ack; the read completes after blank returns.
- **Reset mid-fill:** assert reset at fill address 100 → next cycle `fill_busy_o`=0 and `pal_wr_en_o`=0, and no further writes occur.
